// File: rtl/countdown_timer.sv
// Loadable down-counter with pause and optional auto-reload.
// tc is a one-cycle registered pulse in the cycle q first reads 0.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] rl, rl_n, q_n;
  logic             tc_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      q     <= '0;
      rl    <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      rl    <= rl_n;
      tc    <= tc_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    rl_n    = rl;
    tc_n    = 1'b0;
    if (load) begin
      rl_n    = din;
      q_n     = din;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && (q != '0)) state_n = RUN;
        end
        RUN: begin
          // q==0 in RUN is the expiry cycle: reload or drop back to IDLE
          if (pause) begin
            state_n = RUN;
          end else if (q > WIDTH'(1)) begin
            q_n = q - WIDTH'(1);
          end else if (q == WIDTH'(1)) begin
            q_n  = '0;
            tc_n = 1'b1;
          end else if (auto_reload && (rl != '0)) begin
            q_n = rl;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded random + directed bench for countdown_timer; a count-level
// reference model predicts q/busy/tc after every clock edge.
module tb_countdown_timer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0, start = 1'b0, pause = 1'b0, auto_reload = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic         busy, tc;

  countdown_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .start(start),
    .pause(pause), .auto_reload(auto_reload), .q(q), .busy(busy), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         tc;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  string tag = "reset";

  // reference: remaining count, reload value, running flag, expiry pulse
  int m_q = 0, m_rl = 0;
  bit m_run = 0, m_tc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q = 0; m_rl = 0; m_run = 0; m_tc = 0;
  endfunction

  function automatic void model_edge(bit ld, int d, bit st, bit pa, bit ar);
    m_tc = 0;
    if (ld) begin
      m_rl = d; m_q = d; m_run = 0;
    end else if (!m_run) begin
      if (st && m_q > 0) m_run = 1;
    end else if (pa) begin
      m_tc = 0;
    end else if (m_q >= 1) begin
      m_q  = m_q - 1;
      m_tc = (m_q == 0);
    end else if (ar && m_rl > 0) begin
      m_q = m_rl;
    end else begin
      m_run = 0;
    end
  endfunction

  // drive at negedge, predict at posedge, monitor checks at following negedge
  task automatic step(bit ld, int d, bit st, bit pa, bit ar);
    exp_t e;
    load = ld; din = d[W-1:0]; start = st; pause = pa; auto_reload = ar;
    @(posedge clk);
    if (rst) model_edge(ld, d % (1 << W), st, pa, ar);
    else     model_reset();
    e.q = m_q[W-1:0]; e.busy = m_run; e.tc = m_tc;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk({tag, ".arst_q"},    q,    0);
    chk({tag, ".arst_busy"}, busy, 0);
    chk({tag, ".arst_tc"},   tc,   0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".q"},    q,    e.q);
      chk({tag, ".busy"}, busy, e.busy);
      chk({tag, ".tc"},   tc,   e.tc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("reset.q", q, 0);
    chk("reset.busy", busy, 0);
    chk("reset.tc", tc, 0);
    @(negedge clk);
    step(1, 9, 1, 0, 1);             // ignored while in reset
    step(0, 0, 1, 0, 0);
    rst = 1'b1;

    tag = "zero_start";
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    tag = "oneshot";
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0);

    tag = "autoreload";
    step(1, 3, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    repeat (12) step(0, 0, 1, 0, 1);

    tag = "pause";
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0);

    tag = "midload";
    step(1, 9, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);

    tag = "zero_reload";
    step(1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);

    tag = "pause_at_zero";
    step(1, 2, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);

    tag = "async_rst";
    step(1, 7, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    async_reset();
    step(0, 0, 1, 0, 0);

    tag = "random";
    repeat (600) begin
      if ($urandom_range(0, 80) == 0) async_reset();
      else step($urandom_range(0, 12) == 0, int'($urandom_range(0, (1 << W) - 1)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 2) != 0);
    end

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
